// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM states,
// fixed widths and a digit-range helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BIN_W     = 14;
  localparam int N_DIGITS  = 4;
  localparam int BCD_MAX   = 9;
  localparam int LAST_STEP = 13;
  localparam int BCD_W     = 4 * N_DIGITS;

  // True when any packed 4-bit digit is outside 0..9.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'(BCD_MAX)) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sub3ifge8.sv
// Per-digit correction for the reverse double-dabble: a digit that reads 8
// or more after the right shift is pulled back by 3.
module sub3ifge8 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = d_i[3] ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter using the shift-right /
// subtract-3 algorithm, one result bit per CONV cycle.
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       BCD_0,
  input  logic [3:0]       BCD_1,
  input  logic [3:0]       BCD_2,
  input  logic [3:0]       BCD_3,
  output logic [BIN_W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               bad_q, bad_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       sh_bcd;
  logic [BCD_W-1:0]       adj_bcd;
  logic [BIN_W-1:0]       sh_bin;
  logic [BCD_W-1:0]       in_bcd;

  assign in_bcd  = {BCD_3, BCD_2, BCD_1, BCD_0};
  assign shifted = {bcd_q, bin_q} >> 1;
  assign sh_bcd  = shifted[BCD_W+BIN_W-1:BIN_W];
  assign sh_bin  = shifted[BIN_W-1:0];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    sub3ifge8 u_sub3 (
      .d_i (sh_bcd[4*g +: 4]),
      .d_o (adj_bcd[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = in_bcd;
          bin_d = '0;
          cnt_d = '0;
          bad_d = has_bad_digit(in_bcd);
          if (has_bad_digit(in_bcd)) begin
            state_d = DONE;
          end else begin
            state_d = CONV;
            busy_d  = 1'b1;
          end
        end
      end
      CONV: begin
        bcd_d = adj_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(LAST_STEP)) state_d = DONE;
      end
      DONE: begin
        // Result, err and done all land on the edge that leaves DONE.
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = bad_q;
        if (!bad_q) b_d = bin_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  assign B    = b_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 4 BCD digits in and 14 binary bits out.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  conversion request, sampled on the clock edge.
REQ-005 BCD_0  input  4  ones digit.
REQ-006 BCD_1  input  4  tens digit.
REQ-007 BCD_2  input  4  hundreds digit.
REQ-008 BCD_3  input  4  thousands digit.
REQ-009 B  output  14  binary result, registered.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse marking a completed request.
REQ-012 err  output  1  high when the last request contained a digit greater than 9; valid while done is high and held until the next done.

Function
REQ-013 The FSM SHALL have three states:
- IDLE: waiting for a request.
- CONV: shifting the 14 result bits.
- DONE: signalling completion.
REQ-014 In IDLE, start=1 SHALL capture all four digits into a 16-bit BCD shift register. This sampling edge is called T.
- If any digit is greater than 9, the FSM SHALL go to DONE.
- Otherwise it SHALL go to CONV, with the 4-bit step counter at 0 and the 14-bit binary shift register cleared.
REQ-015 Each CONV cycle SHALL do the following, in order:
- Shift the concatenation {BCD register, binary register} right by 1 bit.
- For each 4-bit digit of the shifted BCD register whose value is 8 or more, subtract 3 from that digit.
- Increment the step counter.
REQ-016 CONV SHALL last exactly 14 cycles. When the counter reaches 13, the next state SHALL be DONE.
REQ-017 For a valid request, B SHALL be loaded from the binary register on edge T+15, and done SHALL be high for the cycle following that edge.
REQ-018 For an invalid request, done and err SHALL rise on edge T+1, and B SHALL keep its previous value.
REQ-019 busy SHALL be high from edge T until the edge on which done rises; busy and done SHALL never be high together.
REQ-020 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-021 start SHALL be ignored in CONV and DONE.
REQ-022 Back-to-back requests SHALL be accepted: a start in the first IDLE cycle after done is sampled normally.
REQ-023 err SHALL update only on the edge that raises done: 1 for an invalid request, 0 for a valid one.
REQ-024 B SHALL equal 1000*BCD_3 + 100*BCD_2 + 10*BCD_1 + BCD_0 for every valid input. The maximum is 9999 (0x270F), so the result never overflows 14 bits.
REQ-025 Input digits SHALL be sampled only at edge T; changes during CONV SHALL not affect the result.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE and B=0, busy=0, done=0, err=0, and clear the counter and both shift registers.
REQ-027 Reset asserted mid-conversion SHALL abort the request with no done pulse; a start in the first cycle after release SHALL be accepted.

Structure
REQ-028 A shared package bcd_pkg SHALL hold the following, for reuse by the existing binary-to-BCD converter:
- the state enumeration (IDLE, CONV, DONE);
- the constants BIN_W=14, N_DIGITS=4, BCD_MAX=9, LAST_STEP=13.
REQ-029 The per-digit correction SHALL be a combinational sub-module, sub3ifge8: 4 bits in, 4 bits out, subtracting 3 when the input is 8 or more. It SHALL be instantiated once per digit.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Digits 0,0,0,0 with start at T -> busy over T..T+15, done at T+15, B=0, err=0.
REQ-032 Digits 9,9,9,9 (BCD_3..BCD_0) -> B=0x270F (9999) with done exactly 15 edges after T; digits 1,2,3,4 -> B=0x04D2 (1234).
REQ-033 BCD_1=0xA with the other digits valid -> done and err at T+1, B unchanged from the prior result, busy never high.
REQ-034 start pulsed again at T+5 with different digits, and digits changed during CONV -> first result correct; second start ignored; no second done.
REQ-035 rst asserted at T+7 of a conversion of 5,0,0,0 -> all outputs 0 immediately, no done; new request 0,0,4,2 started after release -> B=42 after 15 cycles.
REQ-036 Exhaustive randomised sweep of all 10000 valid inputs, with start held high continuously -> every B matches the reference sum and done is spaced 16 cycles apart.
